// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master frame bridge: FSM encoding,
// frame capacity and the control/status bit positions of the master.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_REQ   = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } spi_st_e;

  localparam int SPI_MAX_BYTES = 16;
  localparam int SPI_CTRL_GO   = 7;
  localparam int SPI_STAT_BUSY = 7;
  localparam int SPI_LEN_MSB   = 3;
  localparam int SPI_LEN_LSB   = 0;

  // Byte k of the frame lives MSB-first in the 128-bit word.
  function automatic logic [6:0] slot_lsb(input logic [3:0] k);
    return 7'(8 * (15 - int'(k)));
  endfunction

endpackage

// File: rtl/spi_mst_frame_bridge.sv
// Byte-stream front-end for the SPI master: packs a frame of up to 16 bytes,
// runs one master transfer and streams the received bytes back in wire order.
module spi_mst_frame_bridge
  import spi_pkg::*;
#(
  parameter int MAX_BYTES = SPI_MAX_BYTES
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         tx_valid,
  input  logic [7:0]   tx_data,
  input  logic         tx_last,
  output logic         tx_ready,
  output logic         rx_valid,
  output logic [7:0]   rx_data,
  output logic         rx_last,
  input  logic         rx_ready,
  output logic         busy,
  output logic [127:0] mst_wfifo,
  output logic [7:0]   mst_ctrl,
  input  logic [7:0]   mst_status,
  input  logic [127:0] mst_rfifo
);

  spi_st_e        r_st;
  logic [4:0]     r_cnt;
  logic [3:0]     r_rd;
  logic [127:0]   r_wfifo;
  logic [127:0]   r_rfifo;
  logic [7:0]     r_ctrl;
  logic           r_tx_ready;
  logic           r_busy_q;

  logic           w_tx_hs;
  logic           w_close;
  logic           w_mbusy;
  logic [3:0]     w_last_idx;
  logic [3:0]     w_ridx;
  logic           w_unused;

  assign w_mbusy    = mst_status[SPI_STAT_BUSY];
  assign w_tx_hs    = tx_valid & r_tx_ready;
  // A full buffer closes the frame even without tx_last.
  assign w_close    = tx_last | (r_cnt == 5'(MAX_BYTES - 1));
  assign w_last_idx = r_cnt[3:0] - 4'd1;
  assign w_ridx     = w_last_idx - r_rd;
  assign w_unused   = ^mst_status[6:0];

  assign tx_ready  = r_tx_ready;
  assign busy      = (r_st != ST_IDLE);
  assign rx_valid  = (r_st == ST_DRAIN);
  assign rx_data   = rx_valid ? r_rfifo[{w_ridx, 3'b000} +: 8] : 8'h00;
  assign rx_last   = rx_valid & (r_rd == w_last_idx);
  assign mst_wfifo = r_wfifo;
  assign mst_ctrl  = r_ctrl;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_st       <= ST_IDLE;
      r_cnt      <= '0;
      r_rd       <= '0;
      r_wfifo    <= '0;
      r_rfifo    <= '0;
      r_ctrl     <= '0;
      r_tx_ready <= 1'b0;
      r_busy_q   <= 1'b0;
    end else begin
      r_busy_q <= w_mbusy;
      case (r_st)
        ST_IDLE, ST_FILL: begin
          r_tx_ready <= 1'b1;
          if (w_tx_hs) begin
            r_wfifo[slot_lsb(r_cnt[3:0]) +: 8] <= tx_data;
            r_cnt <= r_cnt + 5'd1;
            if (w_close) begin
              r_st       <= ST_REQ;
              r_tx_ready <= 1'b0;
              // Length field is the new count minus one, i.e. the old count.
              r_ctrl     <= {1'b1, 3'b000, r_cnt[3:0]};
            end else begin
              r_st <= ST_FILL;
            end
          end
        end
        ST_REQ: begin
          if (w_mbusy) begin
            r_ctrl[SPI_CTRL_GO] <= 1'b0;
            r_st                <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (r_busy_q && !w_mbusy) begin
            r_rfifo <= mst_rfifo;
            r_rd    <= '0;
            r_st    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (rx_ready) begin
            if (r_rd == w_last_idx) begin
              r_st       <= ST_IDLE;
              r_cnt      <= '0;
              r_rd       <= '0;
              r_wfifo    <= '0;
              r_ctrl     <= '0;
              r_tx_ready <= 1'b1;
            end else begin
              r_rd <= r_rd + 4'd1;
            end
          end
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mst_frame_bridge.sv
// Randomized bench for spi_mst_frame_bridge with a queue-based frame model
// and a small behavioural SPI master driving busy and the receive word.
module tb_spi_mst_frame_bridge;

  logic         clk = 1'b0;
  logic         rstn;
  logic         tx_valid, tx_last, tx_ready;
  logic [7:0]   tx_data;
  logic         rx_valid, rx_last, rx_ready;
  logic [7:0]   rx_data;
  logic         busy;
  logic [127:0] mst_wfifo, mst_rfifo;
  logic [7:0]   mst_ctrl, mst_status;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] txq[$];
  logic [7:0] rsp[$];

  spi_mst_frame_bridge dut (
    .clk(clk), .rstn(rstn),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last), .rx_ready(rx_ready),
    .busy(busy), .mst_wfifo(mst_wfifo), .mst_ctrl(mst_ctrl),
    .mst_status(mst_status), .mst_rfifo(mst_rfifo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int n, input bit use_last);
    int w;
    for (int i = 0; i < n; i++) begin
      tx_valid = 1'b1;
      tx_data  = txq[i];
      tx_last  = use_last && (i == n - 1);
      w = 0;
      while (!tx_ready && w < 50) begin
        step();
        w++;
      end
      if (!tx_ready) chk("tx_ready_timeout", 0, 1);
      step();
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  // Master model: sees the request, raises busy after dly cycles, holds it
  // for blen cycles, then drops it with rsp shifted into the receive word.
  task automatic master(input int n, input int dly, input int blen);
    logic [127:0] exp_w;
    logic [127:0] rf;
    exp_w = '0;
    for (int k = 0; k < n; k++) exp_w = exp_w | ({120'b0, txq[k]} << (120 - 8 * k));
    chk("ctrl_req", mst_ctrl, {1'b1, 3'b000, 4'(n - 1)});
    chk("wfifo_req", mst_wfifo, exp_w);
    chk("busy_req", busy, 1);
    chk("txr_req", tx_ready, 0);
    repeat (dly) begin
      step();
      chk("go_hold", mst_ctrl[7], 1);
    end
    mst_status = 8'h80;
    step();
    chk("go_drop", mst_ctrl[7], 0);
    chk("wfifo_run", mst_wfifo, exp_w);
    repeat (blen) begin
      step();
      chk("rxv_run", rx_valid, 0);
      chk("txr_run", tx_ready, 0);
    end
    rf = {$urandom, $urandom, $urandom, $urandom};
    foreach (rsp[j]) rf = {rf[119:0], rsp[j]};
    mst_status = {1'b0, 7'($urandom)};
    mst_rfifo  = rf;
    step();
  endtask

  task automatic drain(input int n, input int mode);
    int idx, cyc;
    logic [7:0] pd;
    bit stalled, ph;
    idx = 0; cyc = 0; stalled = 0; ph = 0; pd = '0;
    while (idx < n && cyc < 300) begin
      case (mode)
        0:       rx_ready = 1'b1;
        1:       rx_ready = ph;
        default: rx_ready = 1'($urandom);
      endcase
      chk("rx_valid", rx_valid, 1);
      chk("rx_data", rx_data, rsp[idx]);
      chk("rx_last", rx_last, (idx == n - 1));
      chk("txr_drain", tx_ready, 0);
      if (stalled) chk("rx_hold", rx_data, pd);
      pd = rx_data;
      stalled = !rx_ready;
      if (rx_ready) idx++;
      step();
      cyc++;
      ph = ~ph;
    end
    rx_ready = 1'b0;
    chk("drain_done", idx, n);
    if (mode == 0) chk("rx_rate", cyc, n);
    chk("rxv_idle", rx_valid, 0);
    chk("busy_idle", busy, 0);
    chk("txr_idle", tx_ready, 1);
    chk("ctrl_idle", mst_ctrl, 0);
    chk("wfifo_idle", mst_wfifo, 0);
  endtask

  task automatic run_frame(input int n, input int dly, input int blen, input int mode, input bit loop);
    rsp.delete();
    for (int i = 0; i < n; i++) rsp.push_back(loop ? txq[i] : 8'($urandom));
    push_frame(n, 1'b1);
    master(n, dly, blen);
    drain(n, mode);
  endtask

  task automatic rand_tx(input int n);
    txq.delete();
    for (int i = 0; i < n; i++) txq.push_back(8'($urandom));
  endtask

  initial begin
    logic [7:0] b17;
    rstn = 1'b0; tx_valid = 0; tx_data = 0; tx_last = 0; rx_ready = 0;
    mst_status = 0; mst_rfifo = 0;
    step(); step();
    chk("rst_txr", tx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ctrl", mst_ctrl, 0);
    chk("rst_wfifo", mst_wfifo, 0);
    chk("rst_rx", {rx_valid, rx_last, rx_data}, 0);
    rstn = 1'b1;
    step();
    chk("post_rst_txr", tx_ready, 1);

    txq = '{8'h5A}; rsp = '{8'hA5};
    push_frame(1, 1'b1);
    master(1, 2, 3);
    drain(1, 0);

    txq = '{8'h11, 8'h22, 8'h33};
    run_frame(3, 2, 4, 0, 1'b1);

    rand_tx(16);
    b17 = 8'($urandom);
    rsp.delete();
    for (int i = 0; i < 16; i++) rsp.push_back(txq[i]);
    push_frame(16, 1'b0);
    tx_valid = 1'b1; tx_data = b17; tx_last = 1'b1;
    master(16, 2, 6);
    drain(16, 0);
    txq = '{b17};
    run_frame(1, 1, 2, 0, 1'b1);

    rand_tx(2);
    run_frame(2, 5, 1, 0, 1'b0);

    rand_tx(4);
    run_frame(4, 2, 3, 1, 1'b1);

    rand_tx(3);
    push_frame(3, 1'b1);
    step();
    mst_status = 8'h80;
    step(); step();
    chk("run_busy", busy, 1);
    rstn = 1'b0;
    #1;
    mst_status = 8'h00;
    chk("mid_rst_txr", tx_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ctrl", mst_ctrl, 0);
    chk("mid_rst_wfifo", mst_wfifo, 0);
    chk("mid_rst_rx", {rx_valid, rx_last, rx_data}, 0);
    step(); step();
    rstn = 1'b1;
    step();
    chk("rerst_txr", tx_ready, 1);
    rand_tx(1);
    run_frame(1, 2, 2, 0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      int n;
      n = $urandom_range(1, 16);
      rand_tx(n);
      run_frame(n, $urandom_range(1, 6), $urandom_range(0, 8),
                $urandom_range(0, 2), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mst_frame_bridge.md
# spi_mst_frame_bridge

Byte-stream front-end for the SPI master. Collects a frame of up to 16 bytes over a valid/ready write stream, packs it MSB-first into the master's 128-bit write word, issues the start request, waits for the master's busy flag to fall, then returns the received bytes as a valid/ready read stream in wire order. It is the master's only driver of its write-word, control and status ports.

## Interface
- `MAX_BYTES`, 16: frame capacity in bytes; fixed at 16 to match the 128-bit word and 4-bit length field.
- `clk` in 1: single clock, shared with the SPI master.
- `rstn` in 1: asynchronous, active-low reset.
- `tx_valid` in 1: write byte valid.
- `tx_data` in 8: write byte.
- `tx_last` in 1: marks the last byte of the frame.
- `tx_ready` out 1: write byte accepted when `tx_valid && tx_ready`.
- `rx_valid` out 1: read byte valid.
- `rx_data` out 8: read byte, in the order it was received on the wire.
- `rx_last` out 1: marks the last read byte of the frame.
- `rx_ready` in 1: consumer accepts the read byte.
- `busy` out 1: high whenever the FSM is not IDLE.
- `mst_wfifo` out 128: packed frame; byte k sits in `[127-8k -: 8]`.
- `mst_ctrl` out 8: bit 7 = start request; bits 3:0 = byte count − 1; bits 6:4 = 0.
- `mst_status` in 8: bit 7 = master busy.
- `mst_rfifo` in 128: master receive shift word; LSB holds the newest bit.

## Operation
- FSM states: IDLE, FILL, REQ, RUN, DRAIN.
- **IDLE**
  - `tx_ready`=1.
  - On the first accepted byte: store it, set `cnt`=1, go to FILL. If `tx_last` is set on that byte, go straight to REQ.
- **FILL**
  - `tx_ready`=1.
  - Each accepted byte is written to slot `cnt`, then `cnt` increments.
  - Go to REQ when the accepted byte has `tx_last`, or when it is byte 16 (implicit last).
- **REQ**
  - `mst_ctrl[7]`=1 and `mst_ctrl[3:0]`=`cnt`−1.
  - Hold the request until `mst_status[7]`=1, then drop `mst_ctrl[7]` and go to RUN.
- **RUN**
  - Wait for a falling edge of `mst_status[7]` (sampled 1, now 0).
  - On that edge: register `mst_rfifo`, set `rd`=0, go to DRAIN.
- **DRAIN**
  - `rx_valid`=1.
  - `rx_data` = `rfifo_q[8*(cnt-1-rd) +: 8]`.
  - `rx_last` = (`rd`==`cnt`−1).
  - On each handshake `rd` increments. The handshake on the last byte returns the FSM to IDLE and clears `cnt`.
- `mst_wfifo` stays stable from REQ through RUN. Unused slots are 0. The buffer is cleared on entry to IDLE.
- `tx_ready`=0 in REQ, RUN and DRAIN; no new frame is accepted until the previous one has fully drained.
- Widths: `cnt` is 5 bits (1..16). `rd` is 4 bits. The length field is `cnt`−1, truncated to 4 bits.

## Timing
- Reset values: `tx_ready`=0 during reset and 1 in the first cycle after it; `rx_valid`=0; `rx_data`=0; `rx_last`=0; `busy`=0; `mst_wfifo`=0; `mst_ctrl`=0.
- The cycle after the last-byte handshake has `mst_ctrl[7]`=1 (registered output).
- The master latches the start request and raises busy 2 cycles later. The bridge must tolerate any delay ≥1 cycle.
- `mst_ctrl[7]` falls the cycle after busy is first sampled high.
- `rx_valid` rises 1 cycle after busy is sampled falling.
- The rx stream sustains 1 byte/cycle when `rx_ready` is held high.
- `rx_ready` low holds `rx_data` and `rx_last` stable.
- `tx_valid` in REQ/RUN/DRAIN is ignored, and no data is lost: the producer holds its byte.
- Reset asserted mid-operation: everything returns to reset values immediately. The master is reset by the same `rstn`.

## Structure
- Shared package `spi_pkg`:
  - FSM state encoding.
  - `SPI_MAX_BYTES`=16.
  - `SPI_CTRL_GO`=7 and `SPI_STAT_BUSY`=7 bit indices.
  - Length field `[3:0]`.
- No sub-module is required. The packing and unpacking muxes are inline.

## Test plan
- Single byte 0x5A with `tx_last`:
  - `mst_ctrl`=8'h80 until busy, `mst_wfifo[127:120]`=0x5A, all other bits 0.
  - After busy falls with `mst_rfifo[7:0]`=0xA5: one rx byte 0xA5 with `rx_last`=1.
- Three bytes 0x11,0x22,0x33:
  - `mst_ctrl[3:0]`=2 and `mst_wfifo[127:104]`=24'h112233.
  - Loopback model returns the same bytes in rx order 0x11,0x22,0x33; `rx_last` only on 0x33.
- Seventeen bytes sent with no `tx_last`:
  - The frame closes after byte 16, with `mst_ctrl[3:0]`=4'hF and the last slot = byte 16.
  - `tx_ready`=0 until the drain completes; byte 17 starts the next frame.
- Busy delayed 5 cycles:
  - `mst_ctrl[7]` stays high all 5 cycles and drops 1 cycle after busy rises.
- `rx_ready` toggled 0/1 every cycle during a 4-byte drain:
  - Exactly 4 handshakes, no duplicated or skipped byte, `rx_data` stable while stalled.
- `rstn` pulsed low in RUN:
  - Outputs return to reset values, and a subsequent 1-byte frame completes normally.
